// File: rtl/matmult_seq.sv
// Sequencer for the 2x2 matrix multiply: captures eight operand bytes, issues four
// dot-product jobs to the shared ALU, stores results, then streams them to the SPI transmitter.
//
// state   | meaning
// IDLE    | waiting for operand byte 0
// LOAD    | collecting operand bytes 1..7
// ISSUE   | alu_start pulse, operands for job k presented
// WAIT    | waiting for alu_complete
// WRITE   | mem_wr pulse, result k written at address k
// RDADDR  | mem_addr = k presented to the result memory
// RDDATA  | mem_rdata captured into tx_data
// SEND    | waiting for tx_ready
// SENDGAP | tx_load pulse, one-cycle gap before the next word
module matmult_seq (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        abort,
  output logic        alu_start,
  output logic [7:0]  alu_row0,
  output logic [7:0]  alu_row1,
  output logic [7:0]  alu_col0,
  output logic [7:0]  alu_col1,
  input  logic [17:0] alu_out,
  input  logic        alu_complete,
  output logic        mem_wr,
  output logic [1:0]  mem_addr,
  output logic [17:0] mem_wdata,
  input  logic [17:0] mem_rdata,
  output logic [17:0] tx_data,
  output logic        tx_load,
  input  logic        tx_ready,
  output logic        busy,
  output logic        calc_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_RDADDR,
    S_RDDATA,
    S_SEND,
    S_SENDGAP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  ops_q [8];
  logic [7:0]  ops_d [8];
  logic [17:0] res_q, res_d;
  logic [17:0] txd_q, txd_d;
  logic [7:0]  row0_q, row0_d;
  logic [7:0]  row1_q, row1_d;
  logic [7:0]  col0_q, col0_d;
  logic [7:0]  col1_q, col1_d;
  logic        start_q, start_d;
  logic        wr_q, wr_d;
  logic        load_q, load_d;
  logic        done_q, done_d;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
      txd_q   <= '0;
      row0_q  <= '0;
      row1_q  <= '0;
      col0_q  <= '0;
      col1_q  <= '0;
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      res_q   <= res_d;
      txd_q   <= txd_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      col0_q  <= col0_d;
      col1_q  <= col1_d;
      start_q <= start_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) ops_q[i] <= ops_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    res_d   = res_q;
    txd_d   = txd_q;
    row0_d  = row0_q;
    row1_d  = row1_q;
    col0_d  = col0_q;
    col1_d  = col1_q;
    start_d = 1'b0;
    wr_d    = 1'b0;
    load_d  = 1'b0;
    done_d  = 1'b0;
    for (int i = 0; i < 8; i++) ops_d[i] = ops_q[i];

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            ops_d[cnt_q] = rx_data;
            cnt_d        = 3'd1;
            state_d      = S_LOAD;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            ops_d[cnt_q] = rx_data;
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              k_d     = '0;
              start_d = 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (alu_complete) begin
            res_d   = alu_out;
            wr_d    = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (k_q != 2'd3) begin
            k_d     = k_q + 2'd1;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            k_d     = '0;
            state_d = S_RDADDR;
          end
        end
        S_RDADDR: begin
          state_d = S_RDDATA;
        end
        S_RDDATA: begin
          txd_d   = mem_rdata;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            load_d  = 1'b1;
            state_d = S_SENDGAP;
          end
        end
        S_SENDGAP: begin
          if (k_q != 2'd3) begin
            k_d     = k_q + 2'd1;
            state_d = S_RDADDR;
          end else begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Operands come from the next-cycle byte view so the 8th byte is usable for job 0.
    if (start_d) begin
      row0_d = ops_d[{1'b0, k_d[1], 1'b0}];
      row1_d = ops_d[{1'b0, k_d[1], 1'b1}];
      col0_d = ops_d[{1'b1, 1'b0, k_d[0]}];
      col1_d = ops_d[{1'b1, 1'b1, k_d[0]}];
    end
  end

  assign alu_start = start_q;
  assign alu_row0  = row0_q;
  assign alu_row1  = row1_q;
  assign alu_col0  = col0_q;
  assign alu_col1  = col1_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = k_q;
  assign mem_wdata = res_q;
  assign tx_data   = txd_q;
  assign tx_load   = load_q;
  assign calc_done = done_q;
  // calc_done fires in the first IDLE cycle; busy covers it so busy falls one cycle later.
  assign busy      = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_matmult_seq.sv
// Testbench for matmult_seq: table of operand sets with constant expected products,
// ALU and result-memory models, and a write/transmit scoreboard.
module tb_matmult_seq;

  logic        sys_clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        abort;
  logic        alu_start;
  logic [7:0]  alu_row0, alu_row1, alu_col0, alu_col1;
  logic [17:0] alu_out;
  logic        alu_complete;
  logic        mem_wr;
  logic [1:0]  mem_addr;
  logic [17:0] mem_wdata;
  logic [17:0] mem_rdata;
  logic [17:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic        busy;
  logic        calc_done;

  matmult_seq dut (
    .sys_clk(sys_clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .abort(abort),
    .alu_start(alu_start), .alu_row0(alu_row0), .alu_row1(alu_row1),
    .alu_col0(alu_col0), .alu_col1(alu_col1), .alu_out(alu_out), .alu_complete(alu_complete),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .busy(busy), .calc_done(calc_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0][7:0]  ops;
    logic [3:0][17:0] exp;
    logic [2:0]       lat;
  } vec_t;

  typedef struct packed {
    logic [1:0]  addr;
    logic [17:0] data;
  } wr_t;

  vec_t        vecs [5];
  wr_t         exp_wr_q [$];
  logic [17:0] exp_tx_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  int n_wr = 0;
  int alu_lat = 3;
  logic stray_cmp;
  logic done_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU model: fixed latency, result from the operands seen with alu_start
  logic        alu_busy, alu_complete_m;
  int          alu_cnt;
  logic [17:0] alu_res, alu_out_m;
  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      alu_busy <= 1'b0; alu_cnt <= 0; alu_complete_m <= 1'b0; alu_out_m <= '0; alu_res <= '0;
    end else begin
      alu_complete_m <= 1'b0;
      if (alu_busy) begin
        if (alu_cnt <= 1) begin
          alu_complete_m <= 1'b1; alu_out_m <= alu_res; alu_busy <= 1'b0;
        end else alu_cnt <= alu_cnt - 1;
      end else if (alu_start) begin
        alu_busy <= 1'b1;
        alu_cnt  <= alu_lat;
        alu_res  <= 18'(int'(alu_row0) * int'(alu_col0) + int'(alu_row1) * int'(alu_col1));
      end
    end
  end
  assign alu_complete = alu_complete_m | stray_cmp;
  assign alu_out      = stray_cmp ? 18'h2AAAA : alu_out_m;

  logic [17:0] mem_m [4];
  always @(posedge sys_clk) begin
    if (mem_wr) mem_m[mem_addr] <= mem_wdata;
    mem_rdata <= mem_m[mem_addr];
  end

  // Monitor / scoreboard
  always @(negedge sys_clk) begin
    if (!rst) begin
      done_prev = 1'b0;
    end else begin
      int np;
      np = int'(alu_start) + int'(mem_wr) + int'(tx_load) + int'(calc_done);
      if (np != 0) check("pulse_excl", np, 1);
      if (alu_start) n_start++;
      if (done_prev) check("busy_fall", busy, 0);
      if (calc_done) begin
        check("busy_at_done", busy, 1);
        n_done++;
      end
      done_prev = calc_done;
      if (mem_wr) begin
        n_wr++;
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: addr %0d data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (tx_load) begin
        if (exp_tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: data %0h, none expected", tx_data);
        end else check("tx_data", tx_data, exp_tx_q.pop_front());
      end
    end
  end

  task automatic push_exp(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      exp_wr_q.push_back({2'(k), v.exp[k]});
      exp_tx_q.push_back(v.exp[k]);
    end
  endtask

  task automatic send_bytes(input logic [7:0][7:0] ops, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      rx_valid = 1'b1;
      rx_data  = ops[i];
    end
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int cyc = 0;
    while (n_done == d0 && cyc < 600) begin
      @(negedge sys_clk); #1;
      cyc++;
    end
    if (n_done == d0) check("done_timeout", n_done - d0, 1);
    @(negedge sys_clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int s0, d0;
    alu_lat = int'(v.lat);
    push_exp(v);
    s0 = n_start; d0 = n_done;
    send_bytes(v.ops, 8);
    wait_done(d0);
    check("start_cnt", n_start - s0, 4);
    check("done_cnt", n_done - d0, 1);
    check("sb_empty", exp_wr_q.size() + exp_tx_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, d0, w0, cyc;
    // bytes listed B11..A00 (byte 0 = A00 is rightmost); expected results c11..c00
    vecs[0] = '{ops: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                exp: {18'd50, 18'd43, 18'd22, 18'd19}, lat: 3'd3};
    vecs[1] = '{ops: {8{8'hFF}}, exp: {4{18'h1FC02}}, lat: 3'd1};
    vecs[2] = '{ops: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                exp: {18'd31, 18'd26, 18'd7, 18'd6}, lat: 3'd5};
    vecs[3] = '{ops: {8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd0, 8'd0, 8'd1},
                exp: {18'd6, 18'd7, 18'd8, 18'd9}, lat: 3'd2};
    vecs[4] = '{ops: {8'd40, 8'd30, 8'd20, 8'd10, 8'd25, 8'd50, 8'd100, 8'd200},
                exp: {18'd2000, 18'd1250, 18'd8000, 18'd5000}, lat: 3'd4};

    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; abort = 1'b0; tx_ready = 1'b1; stray_cmp = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_tx_load", tx_load, 0);
    check("rst_calc_done", calc_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_alu_row0", alu_row0, 0);
    @(negedge sys_clk);
    rst = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Stray handshakes plus transmit back-pressure on the basic matrices
    tx_ready = 1'b0;
    alu_lat = 3;
    push_exp(vecs[0]);
    s0 = n_start; d0 = n_done; w0 = n_wr;
    send_bytes(vecs[0].ops, 8);
    check("issue_align", alu_start, 1);
    stray_cmp = 1'b1;
    @(negedge sys_clk);
    stray_cmp = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    cyc = 0;
    while (n_wr < w0 + 4 && cyc < 300) begin
      @(negedge sys_clk); #1;
      cyc++;
    end
    check("bp_writes", n_wr - w0, 4);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (i == 5) begin rx_valid = 1'b1; rx_data = 8'h77; end
      if (i == 6) rx_valid = 1'b0;
      check("bp_no_load", tx_load, 0);
      check("bp_tx_stable", tx_data, vecs[0].exp[0]);
    end
    tx_ready = 1'b1;
    @(negedge sys_clk);
    check("bp_load_latency", tx_load, 1);
    wait_done(d0);
    check("bp_start_cnt", n_start - s0, 4);
    check("bp_sb_empty", exp_wr_q.size() + exp_tx_q.size(), 0);

    // Abort after the 5th byte, then a fresh full load
    s0 = n_start;
    send_bytes(vecs[4].ops, 5);
    abort = 1'b1;
    @(negedge sys_clk); #1;
    check("abort_busy", busy, 0);
    abort = 1'b0;
    repeat (10) @(negedge sys_clk);
    check("abort_no_start", n_start - s0, 0);
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of WAIT, then a fresh load
    alu_lat = 4;
    send_bytes(vecs[1].ops, 8);
    @(negedge sys_clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_alu_start", alu_start, 0);
    check("arst_mem_wr", mem_wr, 0);
    check("arst_tx_load", tx_load, 0);
    check("arst_calc_done", calc_done, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_alu_row0", alu_row0, 0);
    check("arst_alu_col1", alu_col1, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (8) @(negedge sys_clk);
    check("arst_no_write", exp_wr_q.size(), 0);
    run_vec(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
